// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side control bundle of the hazard controller: hazard inputs, stage
// enables/bubbles and the data-memory handshake.
interface pipe_hazard_ctrl_if;
    logic        start_i;
    logic [4:0]  IFID_RegRs_i;
    logic [4:0]  IFID_RegRt_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RegRt_i;
    logic        Branch_taken_i;
    logic        EXMEM_MemRead_i;
    logic        EXMEM_MemWrite_i;
    logic        dmem_ack_i;
    logic        PC_Write_o;
    logic        IFID_Write_o;
    logic        IFID_Flush_o;
    logic        IDEX_Bubble_o;
    logic        EXMEM_Hold_o;
    logic        MEMWB_Bubble_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    // controller side
    modport master (
        input  start_i, IFID_RegRs_i, IFID_RegRt_i, IDEX_MemRead_i, IDEX_RegRt_i,
               Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i,
        output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, EXMEM_Hold_o,
               MEMWB_Bubble_o, dmem_req_o, dmem_we_o, err_o, stall_cnt_o
    );

    // pipeline / memory side
    modport slave (
        output start_i, IFID_RegRs_i, IFID_RegRt_i, IDEX_MemRead_i, IDEX_RegRt_i,
               Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i,
        input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, EXMEM_Hold_o,
               MEMWB_Bubble_o, dmem_req_o, dmem_we_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: memory-wait freeze,
// load-use bubble and branch flush, with a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_hazard_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble;
    logic dmem_req, dmem_we, err, advance, mem_op, load_use;

    // Next-state and Mealy output decode; rst_i forces the frozen reset values.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        we_d         = we_q;
        stall_cnt_d  = stall_cnt_q;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        err          = 1'b0;
        advance      = 1'b0;
        mem_op       = bus.EXMEM_MemRead_i | bus.EXMEM_MemWrite_i;
        load_use     = bus.IDEX_MemRead_i && (bus.IDEX_RegRt_i != 5'd0) &&
                       ((bus.IDEX_RegRt_i == bus.IFID_RegRs_i) ||
                        (bus.IDEX_RegRt_i == bus.IFID_RegRt_i));

        if (rst_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (mem_op) begin
                        dmem_req = 1'b1;
                        dmem_we  = bus.EXMEM_MemWrite_i;
                        if (bus.dmem_ack_i) begin
                            advance = 1'b1;
                        end else begin
                            memwb_bubble = 1'b1;
                            state_d      = S_MEM_WAIT;
                            wait_cnt_d   = 8'd1;
                            we_d         = bus.EXMEM_MemWrite_i;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    dmem_req = 1'b1;
                    dmem_we  = we_q;
                    if (bus.dmem_ack_i) begin
                        advance = 1'b1;
                        state_d = S_RUN;
                    end else if (wait_cnt_q >= TIMEOUT_C) begin
                        memwb_bubble = 1'b1;
                        state_d      = S_ERR;
                    end else begin
                        memwb_bubble = 1'b1;
                        wait_cnt_d   = wait_cnt_q + 8'd1;
                    end
                end
                S_ERR: begin
                    err          = 1'b1;
                    memwb_bubble = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Load-use outranks the branch so a flush never meets a held IF/ID.
            if (advance) begin
                exmem_hold = 1'b0;
                if (load_use) begin
                    idex_bubble = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = bus.Branch_taken_i;
                end
            end else begin
                exmem_hold = 1'b1;
            end

            if ((state_q != S_IDLE) && !pc_write && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // State, wait counter, latched write qualifier and stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 8'd0;
            we_q        <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PC_Write_o     = pc_write;
    assign bus.IFID_Write_o   = ifid_write;
    assign bus.IFID_Flush_o   = ifid_flush;
    assign bus.IDEX_Bubble_o  = idex_bubble;
    assign bus.EXMEM_Hold_o   = exmem_hold;
    assign bus.MEMWB_Bubble_o = memwb_bubble;
    assign bus.dmem_req_o     = dmem_req;
    assign bus.dmem_we_o      = dmem_we;
    assign bus.err_o          = err;
    assign bus.stall_cnt_o    = rst_i ? 16'd0 : stall_cnt_q;
endmodule
